// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor and anything that reads
// its state code.
package pll_lock_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_sup_state_t;

    localparam int PLL_SUP_RST_PULSE_DEF = 16;
    localparam int PLL_SUP_TIMEOUT_DEF   = 65536;
    localparam int PLL_SUP_STABLE_DEF    = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic single-bit two-flop synchronizer, both stages cleared by reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives one PLL's reset, watches its lock output and releases the system reset
// once lock has held for a programmable number of cycles.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int RST_PULSE_CYC    = PLL_SUP_RST_PULSE_DEF,
    parameter int LOCK_TIMEOUT_CYC = PLL_SUP_TIMEOUT_DEF,
    parameter int LOCK_STABLE_CYC  = PLL_SUP_STABLE_DEF,
    parameter int CNT_W            = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lost_cnt
);

    localparam int TMR_W = $clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC)) + 1;
    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    pll_sup_state_t   state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic             pll_rst_q, sys_rst_q;
    logic             retry_inc, lost_inc;
    logic             lk_s;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lk_s)
    );

    // Lock takes priority over the timeout when both land on the same cycle.
    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        lost_inc  = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                if (tmr_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = ST_STABLE;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    state_d   = ST_RESET;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lk_s) state_d = ST_WAIT_LOCK;
                else if (tmr_q == STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d  = ST_RESET;
                    lost_inc = 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        tmr_d       = (state_d != state_q) ? '0 : tmr_q + TMR_W'(1);
        retry_cnt_d = (retry_inc && retry_cnt_q != CNT_MAX) ? retry_cnt_q + CNT_W'(1) : retry_cnt_q;
        lost_cnt_d  = (lost_inc && lost_cnt_q != CNT_MAX) ? lost_cnt_q + CNT_W'(1) : lost_cnt_q;
    end

    // Outputs decode the next state so they move on the same edge as state_q.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            tmr_q       <= '0;
            retry_cnt_q <= '0;
            lost_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            retry_cnt_q <= retry_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
            pll_rst_q   <= (state_d == ST_RESET);
            sys_rst_q   <= (state_d != ST_RUN);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign state     = state_q;
    assign retry_cnt = retry_cnt_q;
    assign lost_cnt  = lost_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for the PLL lock supervisor with short limits (4/32/8, 3-bit counters).
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic [1:0] state;
    logic [2:0] retry_cnt;
    logic [2:0] lost_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (32),
        .LOCK_STABLE_CYC  (8),
        .CNT_W            (3)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .lost_cnt   (lost_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic applyStimulus(input logic rstVal, input logic lockVal, input int nCycles);
        rst        = rstVal;
        pll_locked = lockVal;
        for (int i = 0; i < nCycles; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input int expState, input int expPllRst,
                            input int expSysRst, input int expRetry, input int expLost);
        checkOutput({tag, " state"}, 32'(state), 32'(expState));
        checkOutput({tag, " pll_rst"}, 32'(pll_rst), 32'(expPllRst));
        checkOutput({tag, " sys_rst"}, 32'(sys_rst), 32'(expSysRst));
        checkOutput({tag, " retry_cnt"}, 32'(retry_cnt), 32'(expRetry));
        checkOutput({tag, " lost_cnt"}, 32'(lost_cnt), 32'(expLost));
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Power-up reset
        applyStimulus(1'b1, 1'b0, 2);
        checkAll("reset", 0, 1, 1, 0, 0);

        // Clean bring-up: pll_rst high for 4 cycles
        applyStimulus(1'b0, 1'b0, 3);
        checkAll("bringup rst3", 0, 1, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkAll("bringup wait", 1, 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("bringup still wait", 32'(state), 32'd1);
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("bringup lat2", 32'(state), 32'd1);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("bringup stable", 2, 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 7);
        checkAll("bringup stable end", 2, 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("bringup run", 3, 0, 0, 0, 0);

        // Loss of lock in RUN: one-cycle drop
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("loss edge2", 3, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("loss edge3", 0, 1, 1, 0, 1);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("relock rst", 32'(state), 32'd0);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("relock wait", 1, 0, 1, 0, 1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("relock stable", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b1, 7);
        checkOutput("relock stable end", 32'(sys_rst), 32'd1);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("relock run", 3, 0, 0, 0, 1);

        // Second loss so lost_cnt reaches 2
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 15);
        checkAll("second relock", 3, 0, 0, 0, 2);

        // Reset mid-run clears everything on the next edge
        applyStimulus(1'b1, 1'b0, 1);
        checkAll("midrun reset", 0, 1, 1, 0, 0);

        // Unstable lock: high 5, low 2, then high
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("unstable wait", 32'(state), 32'd1);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("unstable stable", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("unstable still stable", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("unstable abort", 1, 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("unstable restable", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b1, 7);
        checkOutput("unstable sys10", 32'(sys_rst), 32'd1);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("unstable run", 3, 0, 0, 0, 0);

        // Lock arriving on the same cycle as the timeout
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("race wait", 32'(state), 32'd1);
        applyStimulus(1'b0, 1'b0, 29);
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("race tmr31", 32'(state), 32'd1);
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("race lock wins", 2, 0, 1, 0, 0);

        // Repeated timeouts, retry_cnt saturates at 7
        applyStimulus(1'b1, 1'b0, 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 3);
            checkOutput($sformatf("retry%0d rst", k), 32'(state), 32'd0);
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput($sformatf("retry%0d wait", k), 32'(state), 32'd1);
            applyStimulus(1'b0, 1'b0, 31);
            checkOutput($sformatf("retry%0d tmr31", k), 32'(state), 32'd1);
            checkOutput($sformatf("retry%0d sys", k), 32'(sys_rst), 32'd1);
            applyStimulus(1'b0, 1'b0, 1);
            checkAll($sformatf("retry%0d timeout", k), 0, 1, 1, (k > 7) ? 7 : k, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
